// File: rtl/block_expander_pkg.sv
// rtl/block_expander_pkg.sv - shared FSM encoding and helper functions for block_expander
// Contents: state_e (IDLE/FILL/CALC/DRAIN), clog2(), lzc().
package block_expander_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CALC  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Leading-zero count of the low w bits of v (w when all of them are zero).
    function automatic int lzc(input logic [31:0] v, input int w);
        int n;
        n = w;
        // Ascending scan: the highest set bit is the last one to overwrite n.
        for (int i = 0; i < 32; i++) begin
            if (i < w && v[i]) n = w - 1 - i;
        end
        return n;
    endfunction

endpackage

// File: rtl/block_expander_lzc.sv
// rtl/block_expander_lzc.sv - leading-zero counter over the block magnitude word, saturated to SHIFT_MAX
// Ports:
//   acc   in  W    OR of one's-complement magnitudes of the block
//   shift out SHW  min(lzc(acc), SHIFT_MAX)
module block_expander_lzc import block_expander_pkg::*; #(
    parameter int W         = 9,
    parameter int SHIFT_MAX = 2,
    parameter int SHW       = 2
) (
    input  logic [W-1:0]   acc,
    output logic [SHW-1:0] shift
);

    int z;

    always_comb begin
        z = lzc(32'(acc), W);
        if (z > SHIFT_MAX) begin
            shift = SHW'(SHIFT_MAX);
        end else begin
            shift = SHW'(z);
        end
    end

endmodule

// File: rtl/block_expander.sv
// rtl/block_expander.sv - block floating-point expander: buffers a block, picks a common left shift, replays it wider
// Ports:
//   CLK, RST_N               clock, asynchronous active-low reset
//   DIN, DIN_CE, DIN_READY   narrow signed input stream (accepted when DIN_CE && DIN_READY)
//   DOUT, DOUT_CE, DOUT_READY wide scaled output stream (transfer when DOUT_CE && DOUT_READY)
//   BLOCK_START              marks the first output sample of each block
//   SHIFT_OUT                left shift applied to the current output block
// Optional: BLOCK_EXPANDER_ROUND_HALF_EN adds a half-LSB offset into the vacated bits when SHIFT_OUT > 0.
module block_expander import block_expander_pkg::*; #(
    parameter int  DIN_WIDTH  = 10,
    parameter int  DOUT_WIDTH = 12,
    parameter int  BLOCK_LEN  = 64,
    parameter int  SHIFT_MAX  = DOUT_WIDTH - DIN_WIDTH,
    localparam int SHW        = (clog2(SHIFT_MAX + 1) > 0) ? clog2(SHIFT_MAX + 1) : 1
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [DIN_WIDTH-1:0]  DIN,
    input  logic                  DIN_CE,
    output logic                  DIN_READY,
    output logic [DOUT_WIDTH-1:0] DOUT,
    output logic                  DOUT_CE,
    input  logic                  DOUT_READY,
    output logic                  BLOCK_START,
    output logic [SHW-1:0]        SHIFT_OUT
);

    localparam int MW = DIN_WIDTH - 1;
    localparam int CW = (clog2(BLOCK_LEN) > 0) ? clog2(BLOCK_LEN) : 1;
    localparam int RW = CW + 1;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [MW-1:0]         acc_q, acc_d;
    logic [SHW-1:0]        shift_q, shift_d;
    logic [RW-1:0]         rd_q, rd_d;
    logic [DOUT_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_ce_q, dout_ce_d;
    logic                  bs_q, bs_d;
    logic                  wr_en;
    logic                  din_ready;
    logic [MW-1:0]         mag;
    logic [SHW-1:0]        lzc_shift;
    logic [DIN_WIDTH-1:0]  rd_data;
    logic [DOUT_WIDTH-1:0] scaled;

    logic [DIN_WIDTH-1:0]  mem [BLOCK_LEN];

    // One's-complement magnitude: negative values fold onto their bitwise inverse,
    // so the most negative input reads as all ones and forces shift 0.
    assign mag = DIN[MW-1:0] ^ {MW{DIN[DIN_WIDTH-1]}};

    assign rd_data = mem[rd_q[CW-1:0]];

    always_ff @(posedge CLK) begin
        if (wr_en) mem[cnt_q] <= DIN;
    end

    block_expander_lzc #(
        .W        (MW),
        .SHIFT_MAX(SHIFT_MAX),
        .SHW      (SHW)
    ) u_lzc (
        .acc  (acc_q),
        .shift(lzc_shift)
    );

    always_comb begin
        scaled = {{(DOUT_WIDTH - DIN_WIDTH){rd_data[DIN_WIDTH-1]}}, rd_data} << shift_q;
`ifdef BLOCK_EXPANDER_ROUND_HALF_EN
        // Vacated bits are zero, so OR-ing in the half-LSB equals adding it.
        if (shift_q != '0) scaled = scaled | (DOUT_WIDTH'(1) << (shift_q - SHW'(1)));
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        shift_d   = shift_q;
        rd_d      = rd_q;
        dout_d    = dout_q;
        dout_ce_d = dout_ce_q;
        bs_d      = bs_q;
        wr_en     = 1'b0;
        din_ready = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FILL;
            end
            FILL: begin
                din_ready = 1'b1;
                if (DIN_CE) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    acc_d = (cnt_q == '0) ? mag : (acc_q | mag);
                    if (cnt_q == CW'(BLOCK_LEN - 1)) state_d = CALC;
                end
            end
            CALC: begin
                shift_d = lzc_shift;
                rd_d    = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                // dout_q is the prefetch stage: refill it whenever it is empty or being consumed.
                if (!dout_ce_q || DOUT_READY) begin
                    if (rd_q != RW'(BLOCK_LEN)) begin
                        dout_d    = scaled;
                        dout_ce_d = 1'b1;
                        bs_d      = (rd_q == '0);
                        rd_d      = rd_q + 1'b1;
                    end else begin
                        dout_ce_d = 1'b0;
                        bs_d      = 1'b0;
                        cnt_d     = '0;
                        acc_d     = '0;
                        state_d   = FILL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            shift_q   <= '0;
            rd_q      <= '0;
            dout_q    <= '0;
            dout_ce_q <= 1'b0;
            bs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            shift_q   <= shift_d;
            rd_q      <= rd_d;
            dout_q    <= dout_d;
            dout_ce_q <= dout_ce_d;
            bs_q      <= bs_d;
        end
    end

    assign DIN_READY   = din_ready;
    assign DOUT        = dout_q;
    assign DOUT_CE     = dout_ce_q;
    assign BLOCK_START = bs_q;
    assign SHIFT_OUT   = shift_q;

endmodule

// File: tb/tb_block_expander.sv
// tb/tb_block_expander.sv - self-checking bench for block_expander against a queue-based reference model
module tb_block_expander;

    localparam int DW = 10;
    localparam int OW = 12;
    localparam int BL = 4;
    localparam int SM = 2;

    logic          CLK;
    logic          RST_N;
    logic [DW-1:0] DIN;
    logic          DIN_CE;
    logic          DIN_READY;
    logic [OW-1:0] DOUT;
    logic          DOUT_CE;
    logic          DOUT_READY;
    logic          BLOCK_START;
    logic [1:0]    SHIFT_OUT;

    block_expander #(
        .DIN_WIDTH (DW),
        .DOUT_WIDTH(OW),
        .BLOCK_LEN (BL),
        .SHIFT_MAX (SM)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .DIN        (DIN),
        .DIN_CE     (DIN_CE),
        .DIN_READY  (DIN_READY),
        .DOUT       (DOUT),
        .DOUT_CE    (DOUT_CE),
        .DOUT_READY (DOUT_READY),
        .BLOCK_START(BLOCK_START),
        .SHIFT_OUT  (SHIFT_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int val;
        int start;
        int shift;
    } ent_t;

    int   n_checks = 0;
    int   n_errors = 0;
    ent_t exp_q[$];
    ent_t got[$];
    int   blk[$];
    int   exp_ready = 0;
    int   start_pending = 1;
    int   prev_ce = 0;
    int   prev_xfer = 0;
    int   lat = -1;
    int   rdy_mode = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_checks++;
        n_errors++;
        $display("FAIL %s", nm);
    endtask

    // Reference: shift is the largest s <= SM whose scaled peak magnitude still fits.
    task automatic model_block();
        int   mx;
        int   s;
        int   rnd;
        ent_t e;
        mx = 0;
        foreach (blk[i]) begin
            int m;
            m = (blk[i] < 0) ? (-blk[i] - 1) : blk[i];
            if (m > mx) mx = m;
        end
        s = 0;
        while (s < SM && mx < (1 << (DW - 2 - s))) s++;
`ifdef BLOCK_EXPANDER_ROUND_HALF_EN
        rnd = (s > 0) ? (1 << (s - 1)) : 0;
`else
        rnd = 0;
`endif
        foreach (blk[i]) begin
            e.val   = blk[i] * (1 << s) + rnd;
            e.start = (i == 0) ? 1 : 0;
            e.shift = s;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge CLK) begin
        int   nxt_ready;
        int   xfer;
        ent_t e;
        if (!RST_N) begin
            chk("rst_dout", int'(DOUT), 0);
            chk("rst_dout_ce", int'(DOUT_CE), 0);
            chk("rst_din_ready", int'(DIN_READY), 0);
            chk("rst_block_start", int'(BLOCK_START), 0);
            chk("rst_shift_out", int'(SHIFT_OUT), 0);
            exp_q.delete();
            blk.delete();
            exp_ready     = 0;
            start_pending = 1;
            prev_ce       = 0;
            prev_xfer     = 0;
            lat           = -1;
        end else begin
            chk("din_ready", int'(DIN_READY), exp_ready);
            if (DOUT_CE) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_dout_ce");
                end else begin
                    chk("dout", int'($signed(DOUT)), exp_q[0].val);
                    chk("block_start", int'(BLOCK_START), exp_q[0].start);
                    chk("shift_out", int'(SHIFT_OUT), exp_q[0].shift);
                end
            end else if (prev_ce && !prev_xfer) begin
                fail("dout_ce_dropped_without_transfer");
            end
            if (lat >= 0) begin
                lat++;
                if (DOUT_CE) begin
                    chk("first_dout_latency", lat, 3);
                    lat = -1;
                end else if (lat >= 3) begin
                    fail("first_dout_latency_exceeded");
                    lat = -1;
                end
            end
            nxt_ready = exp_ready;
            if (start_pending) begin
                nxt_ready     = 1;
                start_pending = 0;
            end
            if (DIN_CE && exp_ready) begin
                blk.push_back(int'($signed(DIN)));
                if (blk.size() == BL) begin
                    model_block();
                    blk.delete();
                    nxt_ready = 0;
                    lat       = 0;
                end
            end
            xfer = (DOUT_CE && DOUT_READY) ? 1 : 0;
            if (xfer && exp_q.size() > 0) begin
                e.val   = int'($signed(DOUT));
                e.start = int'(BLOCK_START);
                e.shift = int'(SHIFT_OUT);
                got.push_back(e);
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) nxt_ready = 1;
            end
            prev_ce   = DOUT_CE ? 1 : 0;
            prev_xfer = xfer;
            exp_ready = nxt_ready;
        end
    end

    always @(posedge CLK) begin
        #1;
        if (rdy_mode == 1) DOUT_READY = 1'($urandom_range(0, 1));
        else if (rdy_mode == 0) DOUT_READY = 1'b1;
    end

    task automatic push_sample(input int v);
        int g;
        g = 0;
        DIN    = DW'(v);
        DIN_CE = 1'b1;
        do begin
            @(negedge CLK);
            g++;
        end while (!DIN_READY && g < 1000);
        if (!DIN_READY) fail("push_sample_timeout");
        @(posedge CLK);
        #1;
        DIN_CE = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (!(exp_q.size() == 0 && exp_ready == 1) && g < 1000) begin
            @(negedge CLK);
            #1;
            g++;
        end
        if (g >= 1000) fail("drain_timeout");
        @(posedge CLK);
        #1;
    endtask

    task automatic run_directed(input string nm, input int s[4], input int sh, input int e[4]);
        got.delete();
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) push_sample(s[i]);
        wait_drain();
        chk({nm, "_count"}, got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            chk({nm, "_val"}, got[i].val, e[i]);
            chk({nm, "_start"}, got[i].start, (i == 0) ? 1 : 0);
            chk({nm, "_shift"}, got[i].shift, sh);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        RST_N      = 1'b0;
        DIN        = '0;
        DIN_CE     = 1'b0;
        DOUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;

`ifdef BLOCK_EXPANDER_ROUND_HALF_EN
        run_directed("blk_a", '{1, -2, 3, -4}, 2, '{6, -6, 14, -14});
        run_directed("blk_b", '{200, 0, -1, 5}, 1, '{401, 1, -1, 11});
        run_directed("blk_c", '{511, -512, 0, 1}, 0, '{511, -512, 0, 1});
        run_directed("blk_zero", '{0, 0, 0, 0}, 2, '{2, 2, 2, 2});
        run_directed("blk_round", '{3, -4, 0, 1}, 2, '{14, -14, 2, 6});
`else
        run_directed("blk_a", '{1, -2, 3, -4}, 2, '{4, -8, 12, -16});
        run_directed("blk_b", '{200, 0, -1, 5}, 1, '{400, 0, -2, 10});
        run_directed("blk_c", '{511, -512, 0, 1}, 0, '{511, -512, 0, 1});
        run_directed("blk_zero", '{0, 0, 0, 0}, 2, '{0, 0, 0, 0});
        run_directed("blk_round", '{3, -4, 0, 1}, 2, '{12, -16, 0, 4});
`endif

        // Output stall after the second transfer, with input pulses that must be ignored.
        got.delete();
        rdy_mode   = 2;
        DOUT_READY = 1'b1;
        push_sample(7);
        push_sample(-3);
        push_sample(100);
        push_sample(-50);
        g = 0;
        while (got.size() < 2 && g < 200) begin
            @(negedge CLK);
            #1;
            g++;
        end
        if (got.size() < 2) fail("stall_wait_timeout");
        @(posedge CLK);
        #1;
        DOUT_READY = 1'b0;
        repeat (3) begin
            DIN    = DW'(123);
            DIN_CE = 1'b1;
            @(posedge CLK);
            #1;
        end
        DIN_CE     = 1'b0;
        DOUT_READY = 1'b1;
        wait_drain();
        chk("stall_count", got.size(), 4);
        rdy_mode = 0;

        // Reset with a partial block in the buffer.
        push_sample(300);
        push_sample(-7);
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
`ifdef BLOCK_EXPANDER_ROUND_HALF_EN
        run_directed("blk_after_rst", '{-100, 50, 7, 0}, 2, '{-398, 202, 30, 2});
`else
        run_directed("blk_after_rst", '{-100, 50, 7, 0}, 2, '{-400, 200, 28, 0});
`endif

        // Randomized blocks with varying peak magnitude, input gaps and output back-pressure.
        rdy_mode = 1;
        for (int b = 0; b < 30; b++) begin
            int lim;
            case ($urandom_range(0, 3))
                0:       lim = 511;
                1:       lim = 255;
                2:       lim = 127;
                default: lim = 3;
            endcase
            for (int i = 0; i < BL; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge CLK);
                    #1;
                end
                push_sample(int'($urandom_range(0, 2 * lim + 1)) - lim - 1);
            end
        end
        wait_drain();
        rdy_mode = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
